// File: rtl/lif_neuron_core.sv
`default_nettype none
// ============================================================================
// lif_neuron_core -- leaky integrate-and-fire neuron with refractory period
// Revision 1.0
// ============================================================================
module lif_neuron_core #(
  parameter logic signed [7:0] V_RESET = 8'sd0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic signed [7:0] input_current,
  input  logic              current_valid,
  input  logic signed [7:0] threshold,
  input  logic [2:0]        decay,
  input  logic [3:0]        refractory_period,
  input  logic              count_clear,
  output logic signed [7:0] membrane_potential,
  output logic              spike_out,
  output logic              refractory,
  output logic [7:0]        spike_count
);

  typedef enum logic [1:0] {
    INTEGRATE  = 2'd0,
    FIRE       = 2'd1,
    REFRACTORY = 2'd2
  } state_t;

  localparam logic signed [9:0] c_SAT_MAX = 10'sd127;
  localparam logic signed [9:0] c_SAT_MIN = -10'sd128;

  state_t            r_state;
  logic signed [7:0] r_v;
  logic              r_spike;
  logic              r_refr;
  logic [7:0]        r_count;
  logic [3:0]        r_rcnt;

  logic signed [7:0] w_leak;
  logic signed [9:0] w_sum;
  logic signed [7:0] w_vsat;

  // Wide sum: v - leak + current spans -383..382, which fits in 10 bits.
  always_comb begin
    w_leak = (decay == 3'd0) ? 8'sd0 : (r_v >>> decay);
    w_sum  = $signed({{2{r_v[7]}}, r_v})
           - $signed({{2{w_leak[7]}}, w_leak})
           + $signed({{2{input_current[7]}}, input_current});
    if (w_sum > c_SAT_MAX)
      w_vsat = 8'sd127;
    else if (w_sum < c_SAT_MIN)
      w_vsat = -8'sd128;
    else
      w_vsat = w_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= INTEGRATE;
      r_v     <= 8'sd0;
      r_spike <= 1'b0;
      r_refr  <= 1'b0;
      r_count <= 8'd0;
      r_rcnt  <= 4'd0;
    end else begin
      if (count_clear)
        r_count <= 8'd0;
      else if (r_state == FIRE && r_count != 8'hFF)
        r_count <= r_count + 8'd1;

      case (r_state)
        INTEGRATE: begin
          if (current_valid) begin
            r_v <= w_vsat;
            if (w_vsat >= threshold) begin
              r_state <= FIRE;
              r_spike <= 1'b1;
            end
          end
        end
        FIRE: begin
          // Any current_valid seen here is dropped and does not touch r_rcnt.
          r_spike <= 1'b0;
          r_v     <= V_RESET;
          r_rcnt  <= refractory_period;
          if (refractory_period == 4'd0) begin
            r_state <= INTEGRATE;
            r_refr  <= 1'b0;
          end else begin
            r_state <= REFRACTORY;
            r_refr  <= 1'b1;
          end
        end
        REFRACTORY: begin
          r_v <= V_RESET;
          if (current_valid) begin
            if (r_rcnt <= 4'd1) begin
              r_rcnt  <= 4'd0;
              r_state <= INTEGRATE;
              r_refr  <= 1'b0;
            end else begin
              r_rcnt <= r_rcnt - 4'd1;
            end
          end
        end
        default: begin
          r_state <= INTEGRATE;
          r_spike <= 1'b0;
          r_refr  <= 1'b0;
        end
      endcase
    end
  end

  assign membrane_potential = r_v;
  assign spike_out          = r_spike;
  assign refractory         = r_refr;
  assign spike_count        = r_count;

endmodule
`default_nettype wire

// File: doc/lif_neuron_core.md
LIF_NEURON_CORE -- requirements
Module: lif_neuron_core

Interface
REQ-001 Parameter V_RESET, default 0: signed 8-bit membrane value loaded after a spike.
REQ-002 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 Port reset_n, input, 1: synchronous active-low reset.
REQ-004 Port input_current, input, 8: signed synaptic current from the upstream input-current stage.
REQ-005 Port current_valid, input, 1: one-cycle strobe marking input_current as one timestep's value.
REQ-006 Port threshold, input, 8: signed firing threshold, sampled at use.
REQ-007 Port decay, input, 3: leak shift amount; 0 means no leak.
REQ-008 Port refractory_period, input, 4: number of timesteps discarded after a spike.
REQ-009 Port count_clear, input, 1: synchronous clear of spike_count.
REQ-010 Port membrane_potential, output, 8: signed registered membrane value.
REQ-011 Port spike_out, output, 1: registered spike pulse, exactly one cycle wide.
REQ-012 Port refractory, output, 1: high while the state is REFRACTORY.
REQ-013 Port spike_count, output, 8: unsigned spike counter that saturates at 255.

Function
REQ-014 The FSM SHALL have three states, encoded INTEGRATE=0, FIRE=1 and REFRACTORY=2; the encoding 3 SHALL return to INTEGRATE on the next cycle.
REQ-015 The leak term SHALL be membrane_potential arithmetic-shifted right by decay, or 0 when decay=0.
REQ-016 In INTEGRATE with current_valid=1, v_next SHALL be computed in at least 10-bit signed arithmetic as v - leak + input_current.
REQ-017 v_next SHALL saturate to the range [-128, +127] before it is stored.
REQ-018 In INTEGRATE, if saturated v_next >= threshold (signed compare), the block SHALL store v_next and enter FIRE.
REQ-019 Otherwise the block SHALL store v_next and remain in INTEGRATE.
REQ-020 In INTEGRATE with current_valid=0, the membrane and state SHALL hold.
REQ-021 FIRE SHALL last exactly one cycle with spike_out=1 in that cycle, and membrane_potential SHALL load V_RESET at the end of it.
REQ-022 On leaving FIRE, the refractory counter SHALL load refractory_period.
REQ-023 On leaving FIRE, the next state SHALL be INTEGRATE if refractory_period=0, else REFRACTORY.
REQ-024 A current_valid arriving during FIRE SHALL be discarded and SHALL NOT decrement the refractory counter.
REQ-025 In REFRACTORY, each current_valid SHALL be discarded and SHALL decrement the counter.
REQ-026 In REFRACTORY, when current_valid arrives with counter=1, the next state SHALL be INTEGRATE; the membrane SHALL stay at V_RESET throughout REFRACTORY.
REQ-027 spike_count SHALL increment at the end of each FIRE cycle and saturate at 255.
REQ-028 count_clear SHALL zero spike_count and SHALL take priority over a simultaneous increment.
REQ-029 The input-to-spike latency SHALL be: spike_out goes high on the cycle after the current_valid that crosses threshold.
REQ-030 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-031 With reset_n=0 at a clock edge, the block SHALL set membrane_potential=0, spike_out=0, refractory=0, spike_count=0, refractory counter=0 and state=INTEGRATE.
REQ-032 reset_n SHALL override all other inputs.
REQ-033 Reset asserted mid-FIRE or mid-REFRACTORY SHALL abort that state with no residual spike pulse.

Verification
REQ-034 Reset: hold reset_n=0 for 2 cycles with current_valid=1 and input_current=100 -> membrane=0, spike_out=0, spike_count=0; the first valid after release integrates normally.
REQ-035 Integrate/fire: threshold=50, decay=0, refractory_period=0, currents 20,20,20:
- membrane goes 20, then 40, then 60;
- spike_out pulses once on the cycle after the third valid;
- membrane returns to 0 the following cycle and spike_count=1.
REQ-036 Leak: set membrane to 64 with threshold=127, then decay=1 and current 0, twice -> 32, then 16; membrane -1 with decay=1 and current 0 -> 0.
REQ-037 Saturation:
- membrane 120 plus current 100 -> 127 (threshold=127 fires);
- membrane -100 plus current -128 with threshold=0 -> -128 and no spike.
REQ-038 Refractory: refractory_period=2, spike generated -> the next 2 valids (current 50 each) are ignored with refractory=1 and membrane=0; the 3rd valid integrates to 50.
REQ-039 Boundaries:
- spike_count at 255 plus a spike -> stays 255;
- count_clear coincident with a spike -> 0;
- reset_n=0 in REFRACTORY -> state INTEGRATE, refractory=0.
